lcd_sequencer: RTL and testbench

- Drives the HD44780-compatible 16x2 character LCD on the DE2 board in place of the Qsys character-LCD core.
- After reset, runs a fixed power-up and initialisation sequence. It then accepts command and data bytes from a requester over a valid/ready handshake.
- Generates the RS/RW/EN/DATA bus with setup, pulse, hold and execution-wait timing, all counted in clock cycles.
- Sits between a Nios/Avalon-side requester and the LCD_* top-level pins.

---
 rtl/lcd_sequencer.sv | 176 +++++++++++++++++
 tb/tb_lcd_sequencer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_sequencer.sv
// HD44780 character-LCD write sequencer: power-up delay, fixed init ROM, then
// valid/ready byte writes with cycle-counted setup, enable pulse, hold and execution wait.
module lcd_sequencer #(
  parameter int POWERUP_CYCLES    = 750000,
  parameter int SETUP_CYCLES      = 2,
  parameter int EN_HIGH_CYCLES    = 12,
  parameter int HOLD_CYCLES       = 1,
  parameter int SHORT_WAIT_CYCLES = 2000,
  parameter int LONG_WAIT_CYCLES  = 82000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cmd_valid,
  input  logic       cmd_rs,
  input  logic [7:0] cmd_data,
  output logic       cmd_ready,
  input  logic       backlight,
  output logic       init_done,
  output logic [7:0] lcd_data,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en,
  output logic       lcd_on,
  output logic       lcd_blon
);

  localparam int MAX_A   = (POWERUP_CYCLES > SETUP_CYCLES) ? POWERUP_CYCLES : SETUP_CYCLES;
  localparam int MAX_B   = (EN_HIGH_CYCLES > HOLD_CYCLES) ? EN_HIGH_CYCLES : HOLD_CYCLES;
  localparam int MAX_C   = (SHORT_WAIT_CYCLES > LONG_WAIT_CYCLES) ? SHORT_WAIT_CYCLES : LONG_WAIT_CYCLES;
  localparam int MAX_AB  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int MAX_CYC = (MAX_AB > MAX_C) ? MAX_AB : MAX_C;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] PU_LAST = CNT_W'(POWERUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] SU_LAST = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] EN_LAST = CNT_W'(EN_HIGH_CYCLES - 1);
  localparam logic [CNT_W-1:0] HO_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] SW_LAST = CNT_W'(SHORT_WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] LW_LAST = CNT_W'(LONG_WAIT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_POWERUP, S_SETUP, S_PULSE, S_HOLD, S_WAIT, S_IDLE
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [2:0]       idx, idx_next;
  logic             long_q;
  logic             done_next;
  logic             load;
  logic             load_rs;
  logic [7:0]       load_data;
  logic             load_long;
  logic             cmd_is_long;

  function automatic logic [7:0] init_rom(input logic [2:0] i);
    case (i)
      3'd4:    return 8'h0C;
      3'd5:    return 8'h01;
      3'd6:    return 8'h06;
      default: return 8'h38;
    endcase
  endfunction

  // The first function-set write and the clear both need the long execution wait.
  function automatic logic init_long(input logic [2:0] i);
    return (i == 3'd0) || (i == 3'd5);
  endfunction

  assign cmd_is_long = !cmd_rs && ((cmd_data == 8'h01) || (cmd_data == 8'h02) ||
                                   (cmd_data == 8'h03));

  always_comb begin
    state_next = state;
    cnt_next   = cnt + 1'b1;
    idx_next   = idx;
    done_next  = init_done;
    load       = 1'b0;
    load_rs    = 1'b0;
    load_data  = 8'h00;
    load_long  = 1'b0;
    case (state)
      S_POWERUP: begin
        if (cnt == PU_LAST) begin
          state_next = S_SETUP;
          cnt_next   = '0;
          idx_next   = 3'd0;
          load       = 1'b1;
          load_data  = init_rom(3'd0);
          load_long  = init_long(3'd0);
        end
      end
      S_SETUP: begin
        if (cnt == SU_LAST) begin
          state_next = S_PULSE;
          cnt_next   = '0;
        end
      end
      S_PULSE: begin
        if (cnt == EN_LAST) begin
          state_next = S_HOLD;
          cnt_next   = '0;
        end
      end
      S_HOLD: begin
        if (cnt == HO_LAST) begin
          state_next = S_WAIT;
          cnt_next   = '0;
        end
      end
      S_WAIT: begin
        if (cnt == (long_q ? LW_LAST : SW_LAST)) begin
          cnt_next = '0;
          if (!init_done && (idx != 3'd6)) begin
            state_next = S_SETUP;
            idx_next   = idx + 3'd1;
            load       = 1'b1;
            load_data  = init_rom(idx + 3'd1);
            load_long  = init_long(idx + 3'd1);
          end else begin
            state_next = S_IDLE;
            done_next  = 1'b1;
          end
        end
      end
      S_IDLE: begin
        cnt_next = '0;
        if (cmd_valid && cmd_ready) begin
          state_next = S_SETUP;
          load       = 1'b1;
          load_rs    = cmd_rs;
          load_data  = cmd_data;
          load_long  = cmd_is_long;
        end
      end
      default: begin
        state_next = S_POWERUP;
        cnt_next   = '0;
      end
    endcase
  end

  // Every output is a flop; lcd_en and cmd_ready are decoded from the next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_POWERUP;
      cnt       <= '0;
      idx       <= 3'd0;
      long_q    <= 1'b0;
      init_done <= 1'b0;
      cmd_ready <= 1'b0;
      lcd_data  <= 8'h00;
      lcd_rs    <= 1'b0;
      lcd_rw    <= 1'b0;
      lcd_en    <= 1'b0;
      lcd_on    <= 1'b0;
      lcd_blon  <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      idx       <= idx_next;
      init_done <= done_next;
      cmd_ready <= (state_next == S_IDLE) && done_next;
      lcd_en    <= (state_next == S_PULSE);
      lcd_rw    <= 1'b0;
      lcd_on    <= 1'b1;
      lcd_blon  <= backlight;
      if (load) begin
        lcd_rs   <= load_rs;
        lcd_data <= load_data;
        long_q   <= load_long;
      end
    end
  end

endmodule

// File: tb/tb_lcd_sequencer.sv
// Bench for lcd_sequencer: table of requester writes with expected busy time,
// scoreboard of expected LCD bus writes checked at every enable pulse.
module tb_lcd_sequencer;

  localparam int PU = 20, S = 2, E = 4, H = 1, SW = 10, LW = 30;
  localparam int INIT_LAT = PU + 7 * (S + E + H) + 2 * LW + 5 * SW;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_rs = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic       backlight = 1'b1;
  logic       cmd_ready, init_done, lcd_rs, lcd_rw, lcd_en, lcd_on, lcd_blon;
  logic [7:0] lcd_data;

  typedef struct packed {
    logic       rs;
    logic [7:0] data;
  } wr_t;

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         low;
  } vec_t;

  wr_t        exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         pulses = 0;
  bit         rw_bad = 1'b0;
  logic [7:0] rom_exp [7] = '{8'h38, 8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};

  lcd_sequencer #(
    .POWERUP_CYCLES(PU), .SETUP_CYCLES(S), .EN_HIGH_CYCLES(E),
    .HOLD_CYCLES(H), .SHORT_WAIT_CYCLES(SW), .LONG_WAIT_CYCLES(LW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_rs(cmd_rs),
    .cmd_data(cmd_data), .cmd_ready(cmd_ready), .backlight(backlight),
    .init_done(init_done), .lcd_data(lcd_data), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
    .lcd_en(lcd_en), .lcd_on(lcd_on), .lcd_blon(lcd_blon)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Bus monitor: pops the scoreboard on each EN rise, checks width and stability on fall.
  initial begin
    logic       en_prev = 1'b0;
    logic       cap_rs;
    logic [7:0] cap_data;
    bit         stable;
    int         hi_cnt = 0;
    wr_t        e;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        en_prev = 1'b0;
        hi_cnt  = 0;
      end else begin
        if (lcd_rw !== 1'b0) rw_bad = 1'b1;
        if (lcd_en && !en_prev) begin
          pulses++;
          cap_rs   = lcd_rs;
          cap_data = lcd_data;
          stable   = 1'b1;
          hi_cnt   = 1;
          chk("sb_nonempty", (exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("pulse_rs", lcd_rs, e.rs);
            chk("pulse_data", lcd_data, e.data);
          end
        end else if (lcd_en) begin
          hi_cnt++;
          if (lcd_rs !== cap_rs || lcd_data !== cap_data) stable = 1'b0;
        end else if (en_prev) begin
          chk("en_width", hi_cnt, E);
          chk("pulse_stable", stable, 1);
        end
        en_prev = lcd_en;
      end
    end
  end

  task automatic init_seq(input bit with_cmd, input logic [7:0] d);
    int n;
    reset_n   = 1'b0;
    backlight = 1'b1;
    cmd_valid = with_cmd;
    cmd_rs    = 1'b1;
    cmd_data  = d;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_en", lcd_en, 0);
    chk("rst_on", lcd_on, 0);
    chk("rst_blon", lcd_blon, 0);
    chk("rst_data", {lcd_rs, lcd_data}, 0);
    chk("rst_ready_done", {cmd_ready, init_done}, 0);
    exp_q.delete();
    for (int i = 0; i < 7; i++) exp_q.push_back('{1'b0, rom_exp[i]});
    if (with_cmd) exp_q.push_back('{1'b1, d});
    pulses = 0;
    @(negedge clk);
    reset_n = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (n == 1) begin
        chk("lcd_on_first_edge", lcd_on, 1);
        chk("blon_first_edge", lcd_blon, 1);
      end
    end while (!init_done && n < 1000);
    chk("init_latency", n, INIT_LAT);
    chk("init_ready", cmd_ready, 1);
    chk("init_pulses", pulses, 7);
  endtask

  task automatic wait_ready(output int low);
    low = 0;
    while (!cmd_ready && low < 500) begin
      low++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic rs, input logic [7:0] d, output int low);
    int g;
    wait_ready(g);
    chk("ready_before_send", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_rs    = rs;
    cmd_data  = d;
    exp_q.push_back('{rs, d});
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    wait_ready(low);
  endtask

  initial begin
    vec_t       vecs[7];
    logic [7:0] bb[3];
    int         low, g, p0;

    vecs[0] = '{1'b1, 8'h41, S + E + H + SW};
    vecs[1] = '{1'b0, 8'h01, S + E + H + LW};
    vecs[2] = '{1'b0, 8'h80, S + E + H + SW};
    vecs[3] = '{1'b0, 8'h02, S + E + H + LW};
    vecs[4] = '{1'b0, 8'h03, S + E + H + LW};
    vecs[5] = '{1'b1, 8'h01, S + E + H + SW};
    vecs[6] = '{1'b0, 8'h04, S + E + H + SW};

    // Power-up and init from a clean reset.
    init_seq(1'b0, 8'h00);

    // Backlight is a plain one-cycle register.
    backlight = 1'b0;
    #2;
    chk("blon_no_comb_path", lcd_blon, 1);
    @(posedge clk);
    #1;
    chk("blon_latency", lcd_blon, 0);
    backlight = 1'b1;

    // Table-driven single writes with expected busy time.
    for (int i = 0; i < 7; i++) begin
      send(vecs[i].rs, vecs[i].data, low);
      chk($sformatf("busy_len_%0d", i), low, vecs[i].low);
    end
    chk("table_sb_drained", exp_q.size(), 0);

    // Back-to-back with cmd_valid held high.
    bb[0] = 8'h48; bb[1] = 8'h49; bb[2] = 8'h21;
    p0 = pulses;
    cmd_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_ready(low);
      if (k > 0) chk("b2b_busy", low, S + E + H + SW);
      cmd_rs   = 1'b1;
      cmd_data = bb[k];
      exp_q.push_back('{1'b1, bb[k]});
      @(posedge clk);
      #1;
      chk("b2b_accept_once", cmd_ready, 0);
    end
    wait_ready(low);
    cmd_valid = 1'b0;
    chk("b2b_last_busy", low, S + E + H + SW);
    chk("b2b_pulses", pulses - p0, 3);
    chk("b2b_sb_drained", exp_q.size(), 0);

    // Reset asserted in the middle of an enable pulse.
    wait_ready(g);
    cmd_valid = 1'b1;
    cmd_rs    = 1'b1;
    cmd_data  = 8'h55;
    exp_q.push_back('{1'b1, 8'h55});
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    g = 0;
    while (!lcd_en && g < 100) begin
      g++;
      @(posedge clk);
      #1;
    end
    chk("midpulse_en_seen", lcd_en, 1);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_en_drop", lcd_en, 0);
    chk("async_done_drop", init_done, 0);
    chk("async_ready_drop", cmd_ready, 0);
    init_seq(1'b0, 8'h00);

    // Valid held from reset release: must land as the eighth pulse.
    init_seq(1'b1, 8'h5A);
    @(posedge clk);
    #1;
    chk("init_cmd_accept", cmd_ready, 0);
    cmd_valid = 1'b0;
    wait_ready(low);
    chk("init_cmd_busy", low, S + E + H + SW);
    chk("init_cmd_pulses", pulses, 8);
    chk("init_cmd_sb_drained", exp_q.size(), 0);

    chk("rw_always_low", rw_bad, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
